// File: rtl/fpga_config_ctrl_if.sv
// Bitstream word stream between the word source and the configuration controller.
// A word transfers on a rising edge where word_valid and word_ready are both 1.
interface fpga_config_ctrl_if #(
    parameter int WORD_W = 32
) ();
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/fpga_config_ctrl.sv
// CRAM configuration loader: takes bitstream words and shifts them LSB-first
// into the fabric configuration chain, then enables the fabric logic.
module fpga_config_ctrl #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 2048,
    parameter int TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  abort,
    fpga_config_ctrl_if.slave     word_if,
    output logic                  cfg_en,
    output logic                  cfg_bit,
    output logic                  fab_le_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BUR_W = $clog2(WORD_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_SHIFT     = 3'd2,
        S_DONE      = 3'd3,
        S_ERR       = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [WORD_W-1:0]  shreg, shreg_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [BUR_W-1:0]   burst, burst_n;
    logic [TMO_W-1:0]   tmo, tmo_n;
    logic [31:0]        remain;

    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        burst_n   = burst;
        tmo_n     = tmo;
        remain    = 32'(CHAIN_LEN) - 32'(bit_cnt);
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                // abort outranks start even where abort itself is a no-op
                if (start && !abort) begin
                    state_n   = S_WAIT_WORD;
                    bit_cnt_n = '0;
                    tmo_n     = '0;
                end
            end
            S_WAIT_WORD: begin
                if (abort) begin
                    state_n = S_ERR;
                end else if (word_if.word_valid) begin
                    shreg_n = word_if.word_in;
                    burst_n = (remain < 32'(WORD_W)) ? BUR_W'(remain) : BUR_W'(WORD_W);
                    state_n = S_SHIFT;
                end else begin
                    tmo_n = tmo + TMO_W'(1);
                    if (tmo_n == TMO_W'(TIMEOUT)) begin
                        state_n = S_ERR;
                    end
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_n = S_ERR;
                end else begin
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                    burst_n   = burst - BUR_W'(1);
                    if (burst == BUR_W'(1)) begin
                        tmo_n   = '0;
                        state_n = (bit_cnt_n < CNT_W'(CHAIN_LEN)) ? S_WAIT_WORD : S_DONE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state              <= S_IDLE;
            shreg              <= '0;
            bit_cnt            <= '0;
            burst              <= '0;
            tmo                <= '0;
            cfg_en             <= 1'b0;
            cfg_bit            <= 1'b0;
            word_if.word_ready <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            fab_le_en          <= 1'b0;
            err                <= 1'b0;
        end else begin
            state              <= state_n;
            shreg              <= shreg_n;
            bit_cnt            <= bit_cnt_n;
            burst              <= burst_n;
            tmo                <= tmo_n;
            cfg_en             <= (state_n == S_SHIFT);
            cfg_bit            <= (state_n == S_SHIFT) && shreg_n[0];
            word_if.word_ready <= (state_n == S_WAIT_WORD);
            busy               <= (state_n == S_WAIT_WORD) || (state_n == S_SHIFT);
            done               <= (state_n == S_DONE);
            fab_le_en          <= (state_n == S_DONE);
            err                <= (state_n == S_ERR);
        end
    end

endmodule

// File: doc/fpga_config_ctrl.md
FPGA_CONFIG_CTRL -- requirements
Module: fpga_config_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning the width of a bitstream word.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 2048, meaning the total CRAM bits across the fabric chain; legal range is CHAIN_LEN >= 1.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of WAIT_WORD cycles without a word before error.
REQ-004 clk  input  1  CRAM configuration clock; all state updates on its rising edge.
REQ-005 nrst  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to begin loading.
REQ-007 abort  input  1  cancels any load in progress.
REQ-008 word_in  input  WORD_W  bitstream word, with bit 0 shifted first.
REQ-009 word_valid  input  1  word_in is valid.
REQ-010 word_ready  output  1  the block accepts word_in this cycle.
REQ-011 cfg_en  output  1  drives the fabric config_en.
REQ-012 cfg_bit  output  1  drives the fabric config_data_in (head of the chain).
REQ-013 fab_le_en  output  1  logic enable to the fabric; high only when the configuration is complete.
REQ-014 busy  output  1  a load is in progress.
REQ-015 done  output  1  the full chain has been loaded.
REQ-016 err  output  1  the last load ended by timeout or abort.

Function
REQ-017 The block SHALL implement the states IDLE, WAIT_WORD, SHIFT, DONE and ERR.
REQ-018 In IDLE, DONE or ERR, start=1 SHALL move the FSM to WAIT_WORD on the next edge and clear done, err and the bit counter (0..CHAIN_LEN).
REQ-019 start SHALL be ignored in WAIT_WORD and in SHIFT.
REQ-020 word_ready SHALL be 1 only in WAIT_WORD and SHALL be a registered function of state only, with no combinational path from word_valid.
REQ-021 When word_valid and word_ready are both 1, the block SHALL capture word_in into the shift register and enter SHIFT on the next edge.
REQ-022 When word_valid and word_ready are both 1, the block SHALL set the burst length to min(WORD_W, CHAIN_LEN - bits_shifted).
REQ-023 In SHIFT, the block SHALL assert cfg_en=1 with cfg_bit=shreg[0] every cycle, then shift right and increment the bit counter, for exactly the burst length in cycles.
REQ-024 After the last bit of a burst, the FSM SHALL go to WAIT_WORD if bits_shifted < CHAIN_LEN, otherwise to DONE.
REQ-025 cfg_en SHALL be 0 in every state other than SHIFT, including the cycles spent in WAIT_WORD between words.
REQ-026 cfg_bit SHALL be 0 whenever cfg_en=0.
REQ-027 Bits of a final partial word beyond the burst length SHALL be discarded.
REQ-028 The timeout counter SHALL clear on each entry to WAIT_WORD and increment on each WAIT_WORD cycle without a handshake.
REQ-029 When the timeout counter reaches TIMEOUT, the FSM SHALL enter ERR with err=1.
REQ-030 A handshake in the same cycle that the timeout counter reaches TIMEOUT SHALL take priority, so the word is accepted.
REQ-031 abort=1 in WAIT_WORD or SHIFT SHALL move the FSM to ERR on the next edge, with cfg_en=0 from that edge.
REQ-032 abort=1 in IDLE, DONE or ERR SHALL have no effect.
REQ-033 When abort and start are both 1, abort SHALL win.
REQ-034 busy SHALL be 1 exactly in WAIT_WORD and SHIFT.
REQ-035 done and fab_le_en SHALL be 1 exactly in DONE.
REQ-036 err SHALL be 1 exactly in ERR.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 While nrst=0, the FSM SHALL be in IDLE.
REQ-039 While nrst=0, cfg_en, cfg_bit, word_ready, busy, done, err and fab_le_en SHALL be 0.
REQ-040 While nrst=0, the counters and the shift register SHALL be 0.
REQ-041 Reset asserted mid-SHIFT SHALL drop cfg_en immediately (asynchronously), and no further bits SHALL be emitted after release until a new start.

Verification (CHAIN_LEN=40, WORD_W=32, TIMEOUT=8)
REQ-042 Full load: start, then words 0xA5A5_0F0F and 0x0000_00C3 -> 32 cfg_en cycles, cfg_bit LSB-first; then 8 cycles emitting 1,1,0,0,0,0,1,1; done=1 and fab_le_en=1 on the following cycle; 40 cfg_en cycles in total.
REQ-043 Back-pressure: word_valid held low for 5 cycles between the two words -> cfg_en=0 for those cycles, no error, same bit sequence as REQ-042.
REQ-044 Timeout: after the first word, no word_valid -> ERR with err=1 after 8 WAIT_WORD cycles; a later start clears err and reaches WAIT_WORD.
REQ-045 Abort: abort asserted at bit 10 of the first word -> ERR on the next edge, exactly 10 bits emitted, done=0.
REQ-046 Reset mid-load: nrst pulsed low at bit 20 -> all outputs 0 immediately; after release the FSM is in IDLE and a fresh load per REQ-042 succeeds.
REQ-047 Start ignored: start pulsed during SHIFT -> no change in bit count or sequence.
